// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump next-PC, sticky maskable IRQs, EPC and eret.
// Define PC_SEQ_VECTORED_IRQ_EN for one handler vector per line (VEC_BASE + 4*k); otherwise all lines share VEC_BASE.
module pc_sequencer #(
    parameter int unsigned AW       = 32,
    parameter int unsigned NIRQ     = 4,
    parameter logic [31:0] RESET_PC = 32'd128,
    parameter logic [31:0] VEC_BASE = 32'h0000_0040
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            load,
    input  logic [AW-1:0]   entry,
    input  logic            jump,
    input  logic [AW-1:0]   jump_target,
    input  logic            branch_taken,
    input  logic [AW-1:0]   branch_off,
    input  logic            eret,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] irq_mask,
    output logic [AW-1:0]   pc,
    output logic [AW-1:0]   pc_plus4,
    output logic [AW-1:0]   epc,
    output logic [3:0]      cause,
    output logic            in_handler,
    output logic [NIRQ-1:0] irq_ack
);

    localparam logic [0:0]    ST_RUN      = 1'b0;
    localparam logic [0:0]    ST_HANDLER  = 1'b1;
    localparam logic [AW-1:0] RESET_PC_AW = AW'(RESET_PC);
    localparam logic [AW-1:0] VEC_BASE_AW = AW'(VEC_BASE);

    logic [0:0]      state_q,   state_d;
    logic [AW-1:0]   pc_q,      pc_d;
    logic [AW-1:0]   epc_q,     epc_d;
    logic [3:0]      cause_q,   cause_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] ack_q,     ack_d;

    logic [NIRQ-1:0] avail;
    logic [NIRQ-1:0] clear;
    logic [3:0]      take_idx;
    logic            found;
    logic            take;
    logic [AW-1:0]   seq_next;
    logic [AW-1:0]   handler_pc;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:2], 2'b00};
    endfunction

    assign pc_plus4   = pc_q + AW'(4);
    assign pc         = pc_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign irq_ack    = ack_q;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC_AW;
            epc_q     <= '0;
            cause_q   <= '0;
            pending_q <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state: fixed-priority IRQ select, then load > take > eret > sequential
    always_comb begin
        avail    = pending_q & irq_mask;
        take_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (avail[i] && !found) begin
                take_idx = 4'(i);
                found    = 1'b1;
            end
        end
        take  = en && !load && found && (state_q == ST_RUN);
        clear = take ? (NIRQ'(1) << take_idx) : '0;

        if (jump)              seq_next = jump_target;
        else if (branch_taken) seq_next = pc_plus4 + branch_off;
        else                   seq_next = pc_plus4;

`ifdef PC_SEQ_VECTORED_IRQ_EN
        handler_pc = VEC_BASE_AW + AW'({take_idx, 2'b00});
`else
        handler_pc = VEC_BASE_AW;
`endif

        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        pending_d = (pending_q | irq) & ~clear;
        ack_d     = '0;

        if (en) begin
            if (load) begin
                pc_d      = align(entry);
                pending_d = '0;
                state_d   = ST_RUN;
            end else if (take) begin
                pc_d    = align(handler_pc);
                epc_d   = align(seq_next);
                cause_d = take_idx;
                state_d = ST_HANDLER;
                ack_d   = clear;
            end else if (eret && (state_q == ST_HANDLER)) begin
                pc_d    = align(epc_q);
                state_d = ST_RUN;
            end else begin
                pc_d = align(seq_next);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: AW=32 main instance plus an AW=8 instance for wrap-around.
module tb_pc_sequencer;

`ifdef PC_SEQ_VECTORED_IRQ_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [31:0] entry;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_off;
    logic        eret;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic [31:0] pc, pc_plus4, epc;
    logic [3:0]  cause;
    logic        in_handler;
    logic [3:0]  irq_ack;

    logic [7:0]  zero8;
    logic [3:0]  zero4;
    logic [7:0]  pc8, pc_plus4_8, epc8;
    logic [3:0]  cause8;
    logic        in_handler8;
    logic [3:0]  irq_ack8;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.AW(32), .NIRQ(4), .RESET_PC(32'd128), .VEC_BASE(32'h40)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .entry(entry),
        .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_off(branch_off), .eret(eret), .irq(irq), .irq_mask(irq_mask),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .cause(cause),
        .in_handler(in_handler), .irq_ack(irq_ack)
    );

    pc_sequencer #(.AW(8), .NIRQ(4), .RESET_PC(32'd252), .VEC_BASE(32'h40)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(1'b0), .entry(zero8),
        .jump(1'b0), .jump_target(zero8), .branch_taken(1'b0),
        .branch_off(zero8), .eret(1'b0), .irq(zero4), .irq_mask(zero4),
        .pc(pc8), .pc_plus4(pc_plus4_8), .epc(epc8), .cause(cause8),
        .in_handler(in_handler8), .irq_ack(irq_ack8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hvec(input int k);
        return VECTORED ? (32'h40 + 32'(4 * k)) : 32'h40;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        zero8 = '0; zero4 = '0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; entry = '0; jump = 1'b0;
        jump_target = '0; branch_taken = 1'b0; branch_off = '0; eret = 1'b0;
        irq = '0; irq_mask = 4'hF;
        #12;
        chk("rst_pc", pc, 32'd128);
        chk("rst_pc_plus4", pc_plus4, 32'd132);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_in_handler", 32'(in_handler), 32'd0);
        chk("rst_irq_ack", 32'(irq_ack), 32'd0);
        chk("rst_pc8", 32'(pc8), 32'd252);
        chk("rst_pc_plus4_8", 32'(pc_plus4_8), 32'd0);

        rst_n = 1'b1; en = 1'b1;
        step(); chk("seq1", pc, 32'd132);
        chk("wrap_pc8", 32'(pc8), 32'd0);
        step(); chk("seq2", pc, 32'd136);
        step(); chk("seq3", pc, 32'd140);
        chk("seq_epc", epc, 32'd0);
        chk("seq_in_handler", 32'(in_handler), 32'd0);

        load = 1'b1; entry = 32'd200;
        step(); chk("load", pc, 32'd200);
        load = 1'b0; branch_taken = 1'b1; branch_off = 32'hFFFF_FFF8;
        step(); chk("branch_neg", pc, 32'd196);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h100;
        step(); chk("jump", pc, 32'h100);

        // irq[2] lands in pending on the same edge that reaches 0x90
        jump_target = 32'h90; irq = 4'b0100;
        step(); chk("jump_90", pc, 32'h90);
        chk("no_take_yet", 32'(in_handler), 32'd0);
        jump = 1'b0; irq = '0;
        step(); chk("take2_pc", pc, hvec(2));
        chk("take2_epc", epc, 32'h94);
        chk("take2_cause", 32'(cause), 32'd2);
        chk("take2_ack", 32'(irq_ack), 32'b0100);
        chk("take2_inh", 32'(in_handler), 32'd1);
        step(); chk("h2_pc", pc, hvec(2) + 32'd4);
        chk("h2_ack_clr", 32'(irq_ack), 32'd0);
        eret = 1'b1;
        step(); chk("eret2_pc", pc, 32'h94);
        chk("eret2_inh", 32'(in_handler), 32'd0);
        eret = 1'b0;

        irq = 4'b1010;
        step(); chk("pre_dual_pc", pc, 32'h98);
        irq = '0;
        step(); chk("take1_pc", pc, hvec(1));
        chk("take1_cause", 32'(cause), 32'd1);
        chk("take1_epc", epc, 32'h9C);
        chk("take1_ack", 32'(irq_ack), 32'b0010);
        eret = 1'b1;
        step(); chk("eret1_pc", pc, 32'h9C);
        chk("eret1_inh", 32'(in_handler), 32'd0);
        eret = 1'b0;
        step(); chk("take3_pc", pc, hvec(3));
        chk("take3_cause", 32'(cause), 32'd3);
        chk("take3_epc", epc, 32'hA0);
        chk("take3_ack", 32'(irq_ack), 32'b1000);
        eret = 1'b1;
        step(); chk("eret3_pc", pc, 32'hA0);
        eret = 1'b0;

        irq_mask = 4'b1110; irq = 4'b0001;
        step(); chk("mask_pulse_pc", pc, 32'hA4);
        irq = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("masked_pc", pc, 32'hA8 + 32'(4 * i));
            chk("masked_inh", 32'(in_handler), 32'd0);
        end
        irq_mask = 4'hF;
        step(); chk("unmask_pc", pc, hvec(0));
        chk("unmask_cause", 32'(cause), 32'd0);
        chk("unmask_epc", epc, 32'hBC);
        eret = 1'b1;
        step(); chk("eret0_pc", pc, 32'hBC);
        eret = 1'b0;

        en = 1'b0; irq = 4'b0100;
        step(); chk("en0_hold1", pc, 32'hBC);
        chk("en0_inh", 32'(in_handler), 32'd0);
        irq = '0;
        step(); chk("en0_hold2", pc, 32'hBC);
        en = 1'b1;
        step(); chk("en1_take_pc", pc, hvec(2));
        chk("en1_take_epc", epc, 32'hC0);
        chk("en1_take_cause", 32'(cause), 32'd2);

        // Asynchronous reset while in a handler with line 1 pending
        irq = 4'b0010;
        step(); chk("mid_inh", 32'(in_handler), 32'd1);
        irq = '0;
        rst_n = 1'b0;
        #2;
        chk("arst_pc", pc, 32'd128);
        chk("arst_epc", epc, 32'd0);
        chk("arst_cause", 32'(cause), 32'd0);
        chk("arst_inh", 32'(in_handler), 32'd0);
        chk("arst_ack", 32'(irq_ack), 32'd0);
        #2;
        rst_n = 1'b1;
        step(); chk("post_rst1", pc, 32'd132);
        chk("post_rst_inh1", 32'(in_handler), 32'd0);
        step(); chk("post_rst2", pc, 32'd136);
        chk("post_rst_inh2", 32'(in_handler), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
